serial_word_comparator: RTL and testbench

- Sequential MSB-first (left-to-right) magnitude comparator for two WIDTH-bit words.
- Latches A/B on start and walks one bit per clock from MSB to LSB.
- Drives the (y,z) state encoding plus the current bit pair consumed by the downstream combinational comparison stage (system).
- Replaces the behavioural stimulus loop with synthesizable control, so the pair becomes a complete serial comparator.

---
 rtl/comparator_pkg.sv | 20 ++
 rtl/bit_pair_decider.sv | 28 ++
 rtl/serial_word_comparator.sv | 125 ++++++++++++
 tb/tb_serial_word_comparator.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Types and {y,z} encodings shared by the serial comparator and the downstream system stage.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] YZ_IDLE = 2'b00;
    localparam logic [1:0] YZ_EQ   = 2'b01;
    localparam logic [1:0] YZ_AGT  = 2'b10;
    localparam logic [1:0] YZ_BGT  = 2'b11;

    // Both "greater" codes have y set, so y alone marks a settled comparison.
    function automatic logic isResolved(input logic [1:0] yz);
        return yz[1];
    endfunction

endpackage

// File: rtl/bit_pair_decider.sv
// Combinational step of the MSB-first comparison: folds one a/b bit pair into the running {y,z}.
module bit_pair_decider
    import comparator_pkg::*;
(
    input  logic [1:0] curYz,
    input  logic       bitA,
    input  logic       bitB,
    output logic [1:0] nextYz_c,
    output logic       resolved_c
);

    // A settled verdict is sticky; otherwise the first differing pair decides.
    always_comb begin
        nextYz_c = curYz;
        if (!isResolved(curYz)) begin
            if (bitA && !bitB) begin
                nextYz_c = YZ_AGT;
            end else if (!bitA && bitB) begin
                nextYz_c = YZ_BGT;
            end else begin
                nextYz_c = YZ_EQ;
            end
        end
    end

    assign resolved_c = isResolved(nextYz_c);

endmodule

// File: rtl/serial_word_comparator.sv
// Serial MSB-first magnitude comparator: latches A/B on start, walks one bit per clock,
// and publishes the running {y,z} code plus the bit pair under examination.
module serial_word_comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter bit          EARLY_STOP = 1'b1,
    localparam int unsigned IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             y,
    output logic             z,
    output logic             cur_a,
    output logic             cur_b,
    output logic [IDX_W-1:0] bit_idx,
    output logic             eq,
    output logic             a_gt_b,
    output logic             b_gt_a
);

    state_t            state;
    state_t            nextState;
    logic [WIDTH-1:0]  shadowA;
    logic [WIDTH-1:0]  shadowB;
    logic [IDX_W-1:0]  bitIdx;
    logic [1:0]        yzReg;
    logic [1:0]        decYz;
    logic              decResolved;
    logic              lastBit;
    logic              loadJob;
    logic              stepBit;
    logic              finish;

    // Shadow bits indexed by registered state, so they hold after the walk ends.
    assign cur_a   = shadowA[bitIdx];
    assign cur_b   = shadowB[bitIdx];
    assign bit_idx = bitIdx;
    assign y       = yzReg[1];
    assign z       = yzReg[0];
    assign lastBit = (bitIdx == '0);

    bit_pair_decider uDecider (
        .curYz      (yzReg),
        .bitA       (cur_a),
        .bitB       (cur_b),
        .nextYz_c   (decYz),
        .resolved_c (decResolved)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = COMPARE;
            COMPARE: if (lastBit || (EARLY_STOP && decResolved)) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        loadJob = 1'b0;
        stepBit = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE:    loadJob = start;
            COMPARE: begin
                stepBit = 1'b1;
                finish  = (nextState == DONE);
            end
            default: ;
        endcase
    end

    // Datapath and registered status; results only change on load or completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadowA <= '0;
            shadowB <= '0;
            bitIdx  <= '0;
            yzReg   <= YZ_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            a_gt_b  <= 1'b0;
            b_gt_a  <= 1'b0;
        end else begin
            busy <= (nextState == COMPARE);
            done <= (nextState == DONE);
            if (loadJob) begin
                shadowA <= a_in;
                shadowB <= b_in;
                bitIdx  <= IDX_W'(WIDTH - 1);
                yzReg   <= YZ_EQ;
                eq      <= 1'b0;
                a_gt_b  <= 1'b0;
                b_gt_a  <= 1'b0;
            end
            if (stepBit) begin
                yzReg <= decYz;
                if (finish) begin
                    eq     <= (decYz == YZ_EQ);
                    a_gt_b <= (decYz == YZ_AGT);
                    b_gt_a <= (decYz == YZ_BGT);
                end else begin
                    bitIdx <= bitIdx - IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench for serial_word_comparator: directed walks plus random jobs on three configurations,
// checked against an arithmetic model of result and latency.
module tb_serial_word_comparator;

    logic       clk;
    logic       rst;
    logic       startN, startF, startW;
    logic [2:0] aN, bN, aF, bF;
    logic [7:0] aW, bW;

    logic       busyN, doneN, yN, zN, curAN, curBN, eqN, gtN, ltN;
    logic [1:0] idxN;
    logic       busyF, doneF, yF, zF, curAF, curBF, eqF, gtF, ltF;
    logic [1:0] idxF;
    logic       busyW, doneW, yW, zW, curAW, curBW, eqW, gtW, ltW;
    logic [2:0] idxW;

    int nChecks;
    int nFails;
    int sel;

    logic       obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt;
    logic [2:0] obsIdx;

    serial_word_comparator #(.WIDTH(3), .EARLY_STOP(1'b1)) dutN (
        .clk(clk), .rst(rst), .start(startN), .a_in(aN), .b_in(bN),
        .busy(busyN), .done(doneN), .y(yN), .z(zN), .cur_a(curAN), .cur_b(curBN),
        .bit_idx(idxN), .eq(eqN), .a_gt_b(gtN), .b_gt_a(ltN)
    );

    serial_word_comparator #(.WIDTH(3), .EARLY_STOP(1'b0)) dutF (
        .clk(clk), .rst(rst), .start(startF), .a_in(aF), .b_in(bF),
        .busy(busyF), .done(doneF), .y(yF), .z(zF), .cur_a(curAF), .cur_b(curBF),
        .bit_idx(idxF), .eq(eqF), .a_gt_b(gtF), .b_gt_a(ltF)
    );

    serial_word_comparator #(.WIDTH(8), .EARLY_STOP(1'b1)) dutW (
        .clk(clk), .rst(rst), .start(startW), .a_in(aW), .b_in(bW),
        .busy(busyW), .done(doneW), .y(yW), .z(zW), .cur_a(curAW), .cur_b(curBW),
        .bit_idx(idxW), .eq(eqW), .a_gt_b(gtW), .b_gt_a(ltW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1: begin
                {obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt} =
                    {busyF, doneF, yF, zF, curAF, curBF, eqF, gtF, ltF};
                obsIdx = {1'b0, idxF};
            end
            2: begin
                {obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt} =
                    {busyW, doneW, yW, zW, curAW, curBW, eqW, gtW, ltW};
                obsIdx = idxW;
            end
            default: begin
                {obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt} =
                    {busyN, doneN, yN, zN, curAN, curBN, eqN, gtN, ltN};
                obsIdx = {1'b0, idxN};
            end
        endcase
    end

    // Bits examined: through the first differing bit (early stop) or the whole word.
    function automatic int expK(input int w, input bit es, input logic [7:0] a, input logic [7:0] b);
        if (!es) return w;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return w - i;
        end
        return w;
    endfunction

    function automatic logic [1:0] expYz(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return 2'b10;
        if (a < b) return 2'b11;
        return 2'b01;
    endfunction

    task automatic drive(input int s, input logic [7:0] a, input logic [7:0] b, input logic st);
        case (s)
            1:       begin aF = a[2:0]; bF = b[2:0]; startF = st; end
            2:       begin aW = a;      bW = b;      startW = st; end
            default: begin aN = a[2:0]; bN = b[2:0]; startN = st; end
        endcase
    endtask

    task automatic runJob(input int s, input logic [7:0] a, input logic [7:0] b);
        int w, k, edges, busyCnt, idx;
        bit es;
        logic [7:0] ma, mb;
        logic [1:0] yz;
        w  = (s == 2) ? 8 : 3;
        es = (s != 1);
        ma = (w == 8) ? a : {5'b0, a[2:0]};
        mb = (w == 8) ? b : {5'b0, b[2:0]};
        k   = expK(w, es, ma, mb);
        yz  = expYz(ma, mb);
        idx = w - k;
        sel = s;
        @(negedge clk);
        drive(s, ma, mb, 1'b1);
        @(posedge clk); #1;
        edges   = 1;
        busyCnt = obsBusy ? 1 : 0;
        @(negedge clk);
        drive(s, 8'($urandom), 8'($urandom), 1'b0);
        while (obsDone !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (obsBusy === 1'b1) busyCnt++;
        end
        nChecks++;
        if (edges !== k + 1) begin
            nFails++;
            $display("FAIL latency s=%0d a=%h b=%h: got %0d edges, expected %0d", s, ma, mb, edges, k + 1);
        end
        nChecks++;
        if (busyCnt !== k) begin
            nFails++;
            $display("FAIL busy_cycles s=%0d a=%h b=%h: got %0d, expected %0d", s, ma, mb, busyCnt, k);
        end
        nChecks++;
        if ({obsY, obsZ, obsEq, obsGt, obsLt, obsBusy} !==
            {yz, yz == 2'b01, yz == 2'b10, yz == 2'b11, 1'b0}) begin
            nFails++;
            $display("FAIL result s=%0d a=%h b=%h: got yz=%b eq/gt/lt=%b%b%b busy=%b, expected yz=%b",
                     s, ma, mb, {obsY, obsZ}, obsEq, obsGt, obsLt, obsBusy, yz);
        end
        nChecks++;
        if ({obsIdx, obsCurA, obsCurB} !== {3'(idx), ma[idx], mb[idx]}) begin
            nFails++;
            $display("FAIL last_bit s=%0d a=%h b=%h: got idx=%0d cur=%b%b, expected idx=%0d cur=%b%b",
                     s, ma, mb, obsIdx, obsCurA, obsCurB, idx, ma[idx], mb[idx]);
        end
        @(posedge clk); #1;
        nChecks++;
        if ({obsDone, obsBusy, obsY, obsZ, obsEq, obsGt, obsLt} !==
            {2'b00, yz, yz == 2'b01, yz == 2'b10, yz == 2'b11}) begin
            nFails++;
            $display("FAIL hold s=%0d: got done=%b busy=%b yz=%b res=%b%b%b, expected done=0 busy=0 yz=%b",
                     s, obsDone, obsBusy, {obsY, obsZ}, obsEq, obsGt, obsLt, yz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            nChecks++;
            if ({obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt, obsIdx} !== 12'b0) begin
                nFails++;
                $display("FAIL reset_state s=%0d: got %b, expected all zero", s,
                         {obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt, obsIdx});
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_early_walk();
        sel = 0;
        @(negedge clk);
        drive(0, 8'd7, 8'd5, 1'b1);
        @(posedge clk); #1;
        nChecks++;
        if ({obsBusy, obsY, obsZ, obsIdx, obsCurA, obsCurB} !== {1'b1, 2'b01, 3'd2, 2'b11}) begin
            nFails++;
            $display("FAIL early_first: got busy=%b yz=%b idx=%0d cur=%b%b, expected 1 01 2 11",
                     obsBusy, {obsY, obsZ}, obsIdx, obsCurA, obsCurB);
        end
        @(negedge clk);
        drive(0, 8'd7, 8'd5, 1'b0);
        @(posedge clk); #1;
        nChecks++;
        if ({obsBusy, obsY, obsZ, obsIdx, obsCurA, obsCurB} !== {1'b1, 2'b01, 3'd1, 2'b10}) begin
            nFails++;
            $display("FAIL early_second: got busy=%b yz=%b idx=%0d cur=%b%b, expected 1 01 1 10",
                     obsBusy, {obsY, obsZ}, obsIdx, obsCurA, obsCurB);
        end
        @(posedge clk); #1;
        nChecks++;
        if ({obsDone, obsBusy, obsY, obsZ, obsEq, obsGt, obsLt} !== {2'b10, 2'b10, 3'b010}) begin
            nFails++;
            $display("FAIL early_done: got done=%b busy=%b yz=%b res=%b%b%b, expected 1 0 10 010",
                     obsDone, obsBusy, {obsY, obsZ}, obsEq, obsGt, obsLt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_walk();
        logic [2:0] idxSeq [3];
        logic [1:0] yzSeq [3];
        idxSeq = '{3'd2, 3'd1, 3'd0};
        yzSeq  = '{2'b01, 2'b01, 2'b10};
        sel = 1;
        @(negedge clk);
        drive(1, 8'd7, 8'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            nChecks++;
            if ({obsBusy, obsDone, obsIdx, obsY, obsZ} !== {2'b10, idxSeq[i], yzSeq[i]}) begin
                nFails++;
                $display("FAIL full_step%0d: got busy=%b done=%b idx=%0d yz=%b, expected 1 0 %0d %b",
                         i, obsBusy, obsDone, obsIdx, {obsY, obsZ}, idxSeq[i], yzSeq[i]);
            end
            if (i == 0) begin
                @(negedge clk);
                drive(1, 8'd7, 8'd5, 1'b0);
            end
        end
        @(posedge clk); #1;
        nChecks++;
        if ({obsDone, obsBusy, obsY, obsZ, obsIdx, obsGt} !== {2'b10, 2'b10, 3'd0, 1'b1}) begin
            nFails++;
            $display("FAIL full_done: got done=%b busy=%b yz=%b idx=%0d gt=%b, expected 1 0 10 0 1",
                     obsDone, obsBusy, {obsY, obsZ}, obsIdx, obsGt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int edges;
        sel = 0;
        @(negedge clk);
        drive(0, 8'd7, 8'd5, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        drive(0, 8'd0, 8'd7, 1'b1);
        edges = 1;
        while (obsDone !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        nChecks++;
        if ({obsDone, obsGt, obsEq, obsLt} !== 4'b1100) begin
            nFails++;
            $display("FAIL restart_ignored: got done=%b gt/eq/lt=%b%b%b, expected 1 100",
                     obsDone, obsGt, obsEq, obsLt);
        end
        @(posedge clk); #1;
        nChecks++;
        if (obsBusy !== 1'b0) begin
            nFails++;
            $display("FAIL start_in_done: got busy=%b, expected 0", obsBusy);
        end
        @(posedge clk); #1;
        nChecks++;
        if (obsBusy !== 1'b1) begin
            nFails++;
            $display("FAIL start_in_idle: got busy=%b, expected 1", obsBusy);
        end
        @(negedge clk);
        drive(0, 8'd0, 8'd7, 1'b0);
        edges = 1;
        while (obsDone !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        nChecks++;
        if ({obsDone, obsLt, edges} !== {2'b11, 32'd2}) begin
            nFails++;
            $display("FAIL restart_result: got done=%b lt=%b edges=%0d, expected 1 1 2", obsDone, obsLt, edges);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        bit sawDone;
        sel = 0;
        @(negedge clk);
        drive(0, 8'd2, 8'd2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 8'd2, 8'd2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        nChecks++;
        if ({obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt, obsIdx} !== 12'b0) begin
            nFails++;
            $display("FAIL mid_reset: got %b, expected all zero",
                     {obsBusy, obsDone, obsY, obsZ, obsCurA, obsCurB, obsEq, obsGt, obsLt, obsIdx});
        end
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (obsDone === 1'b1 || obsBusy === 1'b1) sawDone = 1'b1;
        end
        nChecks++;
        if (sawDone !== 1'b0) begin
            nFails++;
            $display("FAIL abort_silent: got activity=%b after reset, expected 0", sawDone);
        end
        runJob(0, 8'd2, 8'd2);
    endtask

    task automatic test_boundaries();
        runJob(2, 8'hFF, 8'hFF);
        runJob(2, 8'h00, 8'h00);
        runJob(2, 8'h80, 8'h7F);
        runJob(2, 8'h00, 8'h01);
        runJob(0, 8'd3, 8'd4);
        runJob(1, 8'd2, 8'd2);
        runJob(1, 8'd4, 8'd0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            runJob(int'($urandom_range(2, 0)), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        sel     = 0;
        rst     = 1'b1;
        startN  = 1'b0; startF = 1'b0; startW = 1'b0;
        aN = '0; bN = '0; aF = '0; bF = '0; aW = '0; bW = '0;
        test_reset();
        test_early_walk();
        runJob(0, 8'd2, 8'd2);
        runJob(0, 8'd3, 8'd4);
        test_full_walk();
        test_start_ignored();
        test_mid_reset();
        test_boundaries();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
